spi_mem_responder: RTL and testbench

Serial memory responder: the slave end of the CPU's serial memory bus (chip select, serial clock, data out, data in). It decodes READ/WRITE frames from the CPU's memory master and serves 16-bit words from an internal word-addressed RAM. It is used as the on-die or FPGA-side program/data store and as the bench's memory model for `cpu_top`.

---
 rtl/hack_pkg.sv | 19 +
 rtl/spi_mem_array.sv | 23 ++
 rtl/spi_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_spi_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the serial memory responder: opcodes, field widths
// and the frame-decoder state type.
package hack_pkg;
   localparam int WORD_W = 16;
   localparam int CMD_W  = 8;
   localparam int CNT_W  = $clog2(WORD_W);

   localparam logic [CMD_W-1:0] OP_READ  = 8'h03;
   localparam logic [CMD_W-1:0] OP_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } spi_state_t;
endpackage

// File: rtl/spi_mem_array.sv
// Single-port word RAM with a one-cycle registered read (read-before-write).
module spi_mem_array
   import hack_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] r_mem [2**ADDR_W];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we)
         r_mem[addr] <= wdata;
      r_rdata <= r_mem[addr];
   end

   assign rdata = r_rdata;
endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave decoding READ/WRITE frames (opcode, 16-bit address,
// sequential 16-bit data words) against an internal word RAM.
module spi_mem_responder
   import hack_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic clk,
   input  logic resetb,
   input  logic csb_i,
   input  logic sclk_i,
   input  logic mosi_i,
   output logic miso_o,
   output logic cmd_err_o
);
   logic r_csb_q, r_csb_qq, r_sclk_q, r_sclk_qq, r_mosi_q;
   logic w_rise, w_fall;

   spi_state_t        r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic [WORD_W-1:0] r_shift, w_shift_next, w_shift_in;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic              r_is_read, w_is_read_next;
   logic              r_rd_pend, w_rd_pend_next;
   logic              r_load, w_load_next;
   logic              r_miso, w_miso_next;
   logic              r_cmd_err, w_cmd_err_next;

   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [WORD_W-1:0] w_ram_rdata;

   assign w_rise     = r_sclk_q & ~r_sclk_qq;
   assign w_fall     = ~r_sclk_q & r_sclk_qq;
   assign w_shift_in = {r_shift[WORD_W-2:0], r_mosi_q};

   spi_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (w_ram_we),
      .addr  (w_ram_addr),
      .wdata (w_shift_in),
      .rdata (w_ram_rdata)
   );

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_shift_next   = r_shift;
      w_addr_next    = r_addr;
      w_is_read_next = r_is_read;
      w_rd_pend_next = r_rd_pend;
      w_load_next    = 1'b0;
      w_miso_next    = 1'b0;
      w_cmd_err_next = 1'b0;
      w_ram_we       = 1'b0;
      w_ram_addr     = r_addr;

      // RAM data arrives the cycle after a read is issued; no sclk edge can land here.
      if (r_load)
         w_shift_next = w_ram_rdata;

      if (r_csb_q) begin
         w_state_next   = ST_IDLE;
         w_cnt_next     = '0;
         w_rd_pend_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_csb_qq) begin
                  w_state_next = ST_CMD;
                  w_cnt_next   = '0;
               end
            end
            ST_CMD: begin
               if (w_rise) begin
                  w_shift_next = w_shift_in;
                  w_cnt_next   = r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(CMD_W - 1)) begin
                     w_cnt_next = '0;
                     if (w_shift_in[CMD_W-1:0] == OP_READ || w_shift_in[CMD_W-1:0] == OP_WRITE) begin
                        w_state_next   = ST_ADDR;
                        w_is_read_next = (w_shift_in[CMD_W-1:0] == OP_READ);
                     end else begin
                        w_state_next   = ST_IGNORE;
                        w_cmd_err_next = 1'b1;
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (w_rise) begin
                  w_shift_next = w_shift_in;
                  w_cnt_next   = r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(WORD_W - 1)) begin
                     w_cnt_next  = '0;
                     w_addr_next = w_shift_in[ADDR_W-1:0];
                     if (r_is_read) begin
                        w_state_next = ST_RDATA;
                        w_ram_addr   = w_shift_in[ADDR_W-1:0];
                        w_load_next  = 1'b1;
                     end else begin
                        w_state_next = ST_WDATA;
                     end
                  end
               end
            end
            ST_RDATA: begin
               w_miso_next = r_miso;
               if (w_fall) begin
                  w_miso_next  = r_shift[WORD_W-1];
                  w_shift_next = {r_shift[WORD_W-2:0], 1'b0};
                  w_cnt_next   = r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(WORD_W - 1)) begin
                     w_cnt_next     = '0;
                     w_addr_next    = r_addr + ADDR_W'(1);
                     w_rd_pend_next = 1'b1;
                  end
               end else if (w_rise && r_rd_pend) begin
                  w_rd_pend_next = 1'b0;
                  w_load_next    = 1'b1;
               end
            end
            ST_WDATA: begin
               if (w_rise) begin
                  w_shift_next = w_shift_in;
                  w_cnt_next   = r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(WORD_W - 1)) begin
                     w_cnt_next  = '0;
                     w_ram_we    = 1'b1;
                     w_addr_next = r_addr + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Select registers clear low so a frame only starts after csb is seen high then low.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         r_csb_q   <= 1'b0;
         r_csb_qq  <= 1'b0;
         r_sclk_q  <= 1'b0;
         r_sclk_qq <= 1'b0;
         r_mosi_q  <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_addr    <= '0;
         r_is_read <= 1'b0;
         r_rd_pend <= 1'b0;
         r_load    <= 1'b0;
         r_miso    <= 1'b0;
         r_cmd_err <= 1'b0;
      end else begin
         r_csb_q   <= csb_i;
         r_csb_qq  <= r_csb_q;
         r_sclk_q  <= sclk_i;
         r_sclk_qq <= r_sclk_q;
         r_mosi_q  <= mosi_i;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_shift   <= w_shift_next;
         r_addr    <= w_addr_next;
         r_is_read <= w_is_read_next;
         r_rd_pend <= w_rd_pend_next;
         r_load    <= w_load_next;
         r_miso    <= w_miso_next;
         r_cmd_err <= w_cmd_err_next;
      end
   end

   assign miso_o    = r_miso;
   assign cmd_err_o = r_cmd_err;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench: acts as a mode-0 SPI master issuing READ/WRITE frames.
module tb_spi_mem_responder;
   import hack_pkg::*;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   logic csb = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic miso, cmd_err;

   int tests = 0;
   int fails = 0;
   int err_cnt = 0;
   int miso_cnt = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   spi_mem_responder #(.ADDR_W(8)) dut (
      .clk       (clk),
      .resetb    (resetb),
      .csb_i     (csb),
      .sclk_i    (sclk),
      .mosi_i    (mosi),
      .miso_o    (miso),
      .cmd_err_o (cmd_err)
   );

   always @(negedge clk) begin
      if (mon_en) begin
         if (cmd_err) err_cnt++;
         if (miso) miso_cnt++;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      wait_clk(3);
      sclk = 1'b1;
      r = miso;
      wait_clk(3);
      sclk = 1'b0;
   endtask

   task automatic spi_word(input logic [15:0] tx, input int n, output logic [15:0] rx);
      logic r;
      rx = '0;
      for (int i = 0; i < n; i++) begin
         spi_bit(tx[15-i], r);
         rx = {rx[14:0], r};
      end
   endtask

   task automatic frame_start();
      csb = 1'b0;
      wait_clk(3);
   endtask

   task automatic frame_end();
      wait_clk(3);
      csb = 1'b1;
      mosi = 1'b0;
      wait_clk(4);
   endtask

   task automatic mem_write(input logic [15:0] addr, input logic [15:0] data);
      logic [15:0] d;
      frame_start();
      spi_word({OP_WRITE, 8'h00}, 8, d);
      spi_word(addr, 16, d);
      spi_word(data, 16, d);
      frame_end();
   endtask

   task automatic mem_read(input logic [15:0] addr, output logic [15:0] data);
      logic [15:0] d;
      frame_start();
      spi_word({OP_READ, 8'h00}, 8, d);
      spi_word(addr, 16, d);
      spi_word(16'h0000, 16, data);
      frame_end();
   endtask

   initial begin
      logic [15:0] d, d2;
      logic r;

      // Reset held, then idle with csb high.
      wait_clk(3);
      check("reset_miso", {31'b0, miso}, 32'h0);
      check("reset_cmd_err", {31'b0, cmd_err}, 32'h0);
      resetb = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wait_clk(1);
         check("idle_outputs", {30'b0, miso, cmd_err}, 32'h0);
      end

      // Single write then read back.
      mem_write(16'h0005, 16'hBEEF);
      mem_read(16'h0005, d);
      check("read_addr5", {16'b0, d}, 32'h0000_BEEF);

      // Upper address bits are discarded.
      mem_read(16'h0105, d);
      check("read_upper_bits", {16'b0, d}, 32'h0000_BEEF);

      // Burst write across the wrap point.
      frame_start();
      spi_word({OP_WRITE, 8'h00}, 8, d);
      spi_word(16'h00FF, 16, d);
      spi_word(16'h1111, 16, d);
      spi_word(16'h2222, 16, d);
      frame_end();
      mem_read(16'h0000, d);
      check("wrap_read_addr0", {16'b0, d}, 32'h0000_2222);

      // Burst read across the wrap point.
      frame_start();
      spi_word({OP_READ, 8'h00}, 8, d);
      spi_word(16'h00FF, 16, d);
      spi_word(16'h0000, 16, d);
      spi_word(16'h0000, 16, d2);
      frame_end();
      check("burst_read_w0", {16'b0, d}, 32'h0000_1111);
      check("burst_read_w1", {16'b0, d2}, 32'h0000_2222);

      // Unknown opcode: one error pulse, miso silent, RAM untouched.
      err_cnt = 0;
      miso_cnt = 0;
      mon_en = 1'b1;
      frame_start();
      spi_word({8'h55, 8'h00}, 8, d);
      spi_word(16'h0005, 16, d);
      spi_word(16'h0000, 16, d2);
      frame_end();
      mon_en = 1'b0;
      check("ignore_err_pulses", err_cnt, 32'd1);
      check("ignore_miso_high", miso_cnt, 32'd0);
      check("ignore_sampled", {16'b0, d2}, 32'h0);
      mem_read(16'h0005, d);
      check("ignore_ram_kept", {16'b0, d}, 32'h0000_BEEF);

      // Aborted write leaves the previous word in place.
      mem_write(16'h0003, 16'h1234);
      frame_start();
      spi_word({OP_WRITE, 8'h00}, 8, d);
      spi_word(16'h0003, 16, d);
      spi_word(16'hABCD, 9, d);
      frame_end();
      mem_read(16'h0003, d);
      check("abort_write_read", {16'b0, d}, 32'h0000_1234);

      // Reset in the middle of a read.
      frame_start();
      spi_word({OP_READ, 8'h00}, 8, d);
      spi_word(16'h0005, 16, d);
      mosi = 1'b0;
      wait_clk(3);
      sclk = 1'b1;
      check("midread_bit15", {31'b0, miso}, 32'h1);
      wait_clk(1);
      resetb = 1'b0;
      wait_clk(1);
      check("midread_rst_miso", {31'b0, miso}, 32'h0);
      check("midread_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      resetb = 1'b1;
      wait_clk(2);
      sclk = 1'b0;
      wait_clk(3);
      spi_bit(1'b1, r);
      check("post_rst_idle_miso", {31'b0, r}, 32'h0);
      csb = 1'b1;
      wait_clk(4);
      mem_read(16'h0005, d);
      check("post_rst_read", {16'b0, d}, 32'h0000_BEEF);
      mem_read(16'h0003, d);
      check("post_rst_read3", {16'b0, d}, 32'h0000_1234);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
